// File: rtl/music_pkg.sv
// music_pkg: shared sample limits, saturation helper and mixer FSM encodings.
package music_pkg;
    localparam int SAMPLE_W = 16;
    localparam logic [15:0] SAMPLE_MAX = 16'h7FFF;
    localparam logic [15:0] SAMPLE_MIN = 16'h8000;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] OUT = 2'd2;
    localparam logic [1:0] ECHO = 2'd3;
    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        return v > 32'sd32767 ? SAMPLE_MAX : v < -32'sd32768 ? SAMPLE_MIN : v[15:0];
    endfunction
endpackage

// File: rtl/echo_delay_line.sv
// echo_delay_line: circular sample delay with a fill counter that flags when the line is full.
module echo_delay_line #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        primed
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [15:0] mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW:0] fill;
    always_ff @(posedge clk)
        if (wr_en) mem[ptr] <= din;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ptr <= '0;
            fill <= '0;
        end else if (wr_en) begin
            ptr <= ptr + 1'b1;
            fill <= primed ? fill : fill + 1'b1;
        end
    // the slot about to be overwritten holds the sample written DEPTH mixes ago
    assign dout = mem[ptr];
    assign primed = fill == (AW + 1)'(DEPTH);
endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: sequential N-voice scale/sum/saturate mixer with beat tremolo mute.
// Optional echo stage enabled by defining VOICE_MIXER_ECHO_EN.
module voice_mixer
    import music_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int SHIFT = 2,
    parameter int ECHO_DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [16*NUM_VOICES-1:0]     samples_in,
    input  logic [NUM_VOICES-1:0]        voice_enable,
    input  logic                         latch_in,
    input  logic                         beat,
    input  logic [3:0]                   trem_period,
    output logic [15:0]                  mix_sample,
    output logic                         mix_valid,
    output logic                         overrun,
    output logic                         busy
);
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int IDX_W = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    if (NUM_VOICES < 1 || NUM_VOICES > 8 || SHIFT < 0 || SHIFT > 7 ||
        ECHO_DEPTH < 1 || (ECHO_DEPTH & (ECHO_DEPTH - 1)) != 0)
        $error("voice_mixer: parameter out of range");
    logic [1:0] state;
    logic signed [SAMPLE_W-1:0] snap [NUM_VOICES];
    logic [NUM_VOICES-1:0] en;
    logic [IDX_W-1:0] idx;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic signed [SAMPLE_W-1:0] term;
    logic [3:0] cnt;
    logic mute, last;
    always_comb begin
        term = en[idx] ? (snap[idx] >>> SHIFT) : 16'sd0;
        acc_nxt = acc + ACC_W'(term);
        last = idx == IDX_W'(NUM_VOICES - 1);
    end
    assign busy = state != IDLE;
    assign overrun = latch_in && busy;
    always_ff @(posedge clk)
        if (state == IDLE && latch_in)
            for (int v = 0; v < NUM_VOICES; v++) snap[v] <= samples_in[16*v +: 16];
`ifdef VOICE_MIXER_ECHO_EN
    logic signed [15:0] dry, delayed;
    logic [15:0] line_dout;
    logic primed;
    echo_delay_line #(.DEPTH(ECHO_DEPTH)) u_line (
        .clk(clk),
        .reset(reset),
        .wr_en(state == OUT),
        .din(dry),
        .dout(line_dout),
        .primed(primed)
    );
    assign delayed = primed ? line_dout : 16'h0000;
`endif
    // the saturated result is registered on the last ACCUM edge so mix_valid lands in OUT
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            acc <= '0;
            en <= '0;
            mix_sample <= '0;
            mix_valid <= 1'b0;
`ifdef VOICE_MIXER_ECHO_EN
            dry <= '0;
`endif
        end else begin
            mix_valid <= 1'b0;
            case (state)
                IDLE:
                    if (latch_in) begin
                        en <= voice_enable;
                        acc <= '0;
                        idx <= '0;
                        state <= ACCUM;
                    end
                ACCUM: begin
                    acc <= acc_nxt;
                    idx <= idx + 1'b1;
                    if (last) begin
                        state <= OUT;
`ifdef VOICE_MIXER_ECHO_EN
                        dry <= sat16(32'(acc_nxt));
`else
                        mix_sample <= mute ? 16'h0000 : sat16(32'(acc_nxt));
                        mix_valid <= 1'b1;
`endif
                    end
                end
`ifdef VOICE_MIXER_ECHO_EN
                OUT: begin
                    mix_sample <= mute ? 16'h0000 : sat16(32'(dry) + 32'(delayed >>> 1));
                    mix_valid <= 1'b1;
                    state <= ECHO;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt <= '0;
            mute <= 1'b0;
        end else if (beat) begin
            cnt <= trem_period == 4'd0 ? 4'd0 : cnt == 4'd0 ? trem_period : cnt - 4'd1;
            mute <= trem_period != 4'd0 && cnt == 4'd0;
        end
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: scoreboard bench for voice_mixer; instance a uses SHIFT=2, instance b uses SHIFT=0 and ECHO_DEPTH=4.
// Echo expectations follow VOICE_MIXER_ECHO_EN.
module tb_voice_mixer;
    localparam int NV = 3;
`ifdef VOICE_MIXER_ECHO_EN
    localparam int LAT = NV + 2;
    localparam bit ECHO_ON = 1'b1;
`else
    localparam int LAT = NV + 1;
    localparam bit ECHO_ON = 1'b0;
`endif
    typedef struct {
        logic [15:0] v;
        int due;
    } exp_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, rst_b, latch_a, latch_b, beat_a, beat_b;
    logic [47:0] smp_a, smp_b;
    logic [2:0] en_a, en_b;
    logic [3:0] trem_a, trem_b;
    logic [15:0] ms_a, ms_b;
    logic mv_a, mv_b, ov_a, ov_b, busy_a, busy_b;
    int cyc = 0, total = 0, passed = 0, ov_cnt = 0;
    exp_t qa[$], qb[$];
    exp_t ea, eb;
    voice_mixer #(.NUM_VOICES(NV), .SHIFT(2), .ECHO_DEPTH(64)) u_a (
        .clk(clk), .reset(rst_a), .samples_in(smp_a), .voice_enable(en_a),
        .latch_in(latch_a), .beat(beat_a), .trem_period(trem_a),
        .mix_sample(ms_a), .mix_valid(mv_a), .overrun(ov_a), .busy(busy_a)
    );
    voice_mixer #(.NUM_VOICES(NV), .SHIFT(0), .ECHO_DEPTH(4)) u_b (
        .clk(clk), .reset(rst_b), .samples_in(smp_b), .voice_enable(en_b),
        .latch_in(latch_b), .beat(beat_b), .trem_period(trem_b),
        .mix_sample(ms_b), .mix_valid(mv_b), .overrun(ov_b), .busy(busy_b)
    );
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask
    always @(negedge clk) begin
        if (mv_a) begin
            if (qa.size() == 0) check("unexpected_valid_a", 32'(mv_a), 0);
            else begin
                ea = qa.pop_front();
                check("mix_a", 32'(ms_a), 32'(ea.v));
                check("latency_a", cyc, ea.due);
            end
        end
        if (mv_b) begin
            if (qb.size() == 0) check("unexpected_valid_b", 32'(mv_b), 0);
            else begin
                eb = qb.pop_front();
                check("mix_b", 32'(ms_b), 32'(eb.v));
                check("latency_b", cyc, eb.due);
            end
        end
        if (ov_a || ov_b) ov_cnt++;
    end
    task automatic wait_done(input bit b);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = (b ? qb.size() : qa.size()) == 0;
        end
        if (!done) begin
            check(b ? "timeout_b" : "timeout_a", b ? qb.size() : qa.size(), 0);
            qa.delete();
            qb.delete();
        end
    endtask
    task automatic mix(input bit b, input logic [47:0] s, input logic [2:0] e, input logic [15:0] ex);
        @(posedge clk); #1;
        if (b) begin
            smp_b = s; en_b = e; latch_b = 1'b1;
            qb.push_back('{ex, cyc + LAT});
        end else begin
            smp_a = s; en_a = e; latch_a = 1'b1;
            qa.push_back('{ex, cyc + LAT});
        end
        @(posedge clk); #1;
        latch_a = 1'b0;
        latch_b = 1'b0;
        wait_done(b);
    endtask
    task automatic pulse_beat_a();
        @(posedge clk); #1 beat_a = 1'b1;
        @(posedge clk); #1 beat_a = 1'b0;
    endtask
    task automatic pulse_reset(input bit b);
        @(posedge clk); #1;
        if (b) rst_b = 1'b1; else rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end
    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        latch_a = 1'b0; latch_b = 1'b0; beat_a = 1'b0; beat_b = 1'b0;
        smp_a = '0; smp_b = '0; en_a = '0; en_b = '0; trem_a = '0; trem_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_sample_a", 32'(ms_a), 0);
        check("reset_valid_a", 32'(mv_a), 0);
        check("reset_overrun_a", 32'(ov_a), 0);
        check("reset_busy_a", 32'(busy_a), 0);
        check("reset_sample_b", 32'(ms_b), 0);
        check("reset_valid_b", 32'(mv_b), 0);
        check("reset_overrun_b", 32'(ov_b), 0);
        check("reset_busy_b", 32'(busy_b), 0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        // basic scaled sum: 3 x (0x4000 >>> 2)
        mix(0, {3{16'h4000}}, 3'b111, 16'h3000);
        // second latch two cycles in is dropped and the snapshot survives input changes
        @(posedge clk); #1;
        smp_a = {3{16'h4000}}; en_a = 3'b111; latch_a = 1'b1;
        qa.push_back('{16'h3000, cyc + LAT});
        @(posedge clk); #1 latch_a = 1'b0;
        @(posedge clk); #1;
        smp_a = {3{16'h1000}}; en_a = 3'b001; latch_a = 1'b1;
        @(negedge clk);
        check("overrun_pulse", 32'(ov_a), 1);
        check("busy_during_overrun", 32'(busy_a), 1);
        @(posedge clk); #1;
        latch_a = 1'b0; smp_a = '0;
        wait_done(0);
        check("overrun_count", ov_cnt, 1);
        // tremolo period 2: muted, dry, dry, muted; then period 0 never mutes
        pulse_reset(0);
        trem_a = 4'd2;
        for (int i = 1; i <= 4; i++) begin
            pulse_beat_a();
            mix(0, {3{16'h4000}}, 3'b111, (i == 1 || i == 4) ? 16'h0000 : 16'h3000);
        end
        trem_a = 4'd0;
        for (int i = 0; i < 2; i++) begin
            pulse_beat_a();
            mix(0, {3{16'h4000}}, 3'b111, 16'h3000);
        end
        // saturation on both rails, then masked voice
        mix(1, {3{16'h7000}}, 3'b111, 16'h7FFF);
        mix(1, {3{16'h8000}}, 3'b111, 16'h8000);
        mix(1, {16'hFC00, 16'h7FFF, 16'h0400}, 3'b101, 16'h0000);
        pulse_reset(1);
        for (int i = 1; i <= 5; i++)
            mix(1, {16'h0000, 16'h0000, 16'h2000}, 3'b111, (i == 5 && ECHO_ON) ? 16'h3000 : 16'h2000);
        // asynchronous reset in the middle of ACCUM
        @(posedge clk); #1;
        smp_b = {16'h0000, 16'h0000, 16'h2000}; en_b = 3'b111; latch_b = 1'b1;
        @(posedge clk); #1 latch_b = 1'b0;
        @(posedge clk); #1 rst_b = 1'b1;
        @(negedge clk);
        check("midreset_sample", 32'(ms_b), 0);
        check("midreset_valid", 32'(mv_b), 0);
        check("midreset_busy", 32'(busy_b), 0);
        @(posedge clk); #1 rst_b = 1'b0;
        mix(1, {16'h0000, 16'h0000, 16'h2000}, 3'b111, 16'h2000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("queue_a_empty", qa.size(), 0);
        check("queue_b_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
